// File: rtl/axis2fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis2fifo
// Description : AXI-Stream slave to synchronous-FIFO write-port bridge with a
//               single pipeline register and per-frame word counting.
//               Optional feature macro AXIS2FIFO_MAX_LEN_EN adds a maximum
//               frame length (max_len_i) and a truncation pulse (trunc_o).
// Revision    : 1.0 - initial release
// ============================================================================
module axis2fifo #(
    parameter int DATA_W     = 32,
    parameter int AXIS_LEN_W = 16
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    output logic [AXIS_LEN_W-1:0] len_o,
    output logic                  done_o,
    output logic                  overflow_o,
`ifdef AXIS2FIFO_MAX_LEN_EN
    input  logic [AXIS_LEN_W-1:0] max_len_i,
    output logic                  trunc_o,
`endif
    input  logic                  axis_tvalid_i,
    input  logic [DATA_W-1:0]     axis_tdata_i,
    input  logic                  axis_tlast_i,
    output logic                  axis_tready_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_write_o,
    output logic [DATA_W-1:0]     fifo_wdata_o
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_recv = 2'd1;
    localparam logic [1:0] c_fin  = 2'd2;

    localparam logic [AXIS_LEN_W-1:0] c_cnt_max = '1;
    localparam logic [AXIS_LEN_W-1:0] c_cnt_one = AXIS_LEN_W'(1);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic                  r_last;
    logic [1:0]            r_state;
    logic [AXIS_LEN_W-1:0] r_cnt;
    logic [AXIS_LEN_W-1:0] r_len;
    logic                  r_overflow;
    logic                  r_trunc;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_drain;
    logic                  w_in_frame;
    logic                  w_sat;
    logic                  w_hit_max;
    logic                  w_frame_end;
    logic [AXIS_LEN_W-1:0] w_cnt_next;
    logic [1:0]            w_state_next;

    // Handshakes are qualified by cke_i so a stalled clock neither accepts
    // nor writes a word that the held registers would then duplicate.
    assign w_ready  = cke_i & en_i & ~rst_i & (~r_valid | ~fifo_full_i);
    assign w_accept = axis_tvalid_i & w_ready;
    assign w_drain  = cke_i & ~rst_i & r_valid & ~fifo_full_i;

    // Counter advances on FIFO writes; IDLE and FIN both start a new frame.
    assign w_in_frame = (r_state == c_recv);
    assign w_sat      = w_in_frame & (r_cnt == c_cnt_max);
    assign w_cnt_next = !w_in_frame ? c_cnt_one :
                        (w_sat ? r_cnt : r_cnt + c_cnt_one);

`ifdef AXIS2FIFO_MAX_LEN_EN
    assign w_hit_max = (max_len_i != '0) & (w_cnt_next == max_len_i) & ~r_last;
`else
    assign w_hit_max = 1'b0;
`endif

    assign w_frame_end = r_last | w_hit_max;

    always_comb begin
        w_state_next = r_state;
        if (w_drain) begin
            w_state_next = w_frame_end ? c_fin : c_recv;
        end else if (r_state != c_recv) begin
            w_state_next = c_idle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                r_valid    <= 1'b0;
                r_data     <= '0;
                r_last     <= 1'b0;
                r_state    <= c_idle;
                r_cnt      <= '0;
                r_len      <= '0;
                r_overflow <= 1'b0;
                r_trunc    <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_data <= axis_tdata_i;
                    r_last <= axis_tlast_i;
                end
                r_valid <= w_accept | (r_valid & ~w_drain);
                r_state <= w_state_next;
                if (w_drain) begin
                    r_cnt <= w_cnt_next;
                end
                if (w_drain & w_frame_end) begin
                    r_len <= w_cnt_next;
                end
                if (w_drain & w_sat) begin
                    r_overflow <= 1'b1;
                end
                r_trunc <= w_drain & w_hit_max;
            end
        end
    end

    assign axis_tready_o = w_ready;
    assign fifo_write_o  = w_drain;
    assign fifo_wdata_o  = r_data;
    assign len_o         = r_len;
    assign done_o        = (r_state == c_fin);
    assign overflow_o    = r_overflow;

`ifdef AXIS2FIFO_MAX_LEN_EN
    assign trunc_o = r_trunc;
`else
    logic w_unused;
    assign w_unused = r_trunc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis2fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis2fifo
// Description : Scoreboard testbench for axis2fifo (16-bit and 2-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis2fifo;

    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        full = 1'b0;
    logic [15:0] max_len = '0;

    logic [15:0] len;
    logic        done, ovf, tready, fwrite, trunc;
    logic [31:0] fwdata;
    logic [1:0]  len_s;
    logic        done_s, ovf_s, tready_s, fwrite_s, trunc_s;
    logic [31:0] fwdata_s;

    int checks = 0;
    int failures = 0;
    int writes = 0;
    int dones = 0;
    int cyc = 0;
    int prev_done_cyc = 0;
    int last_done_cyc = 0;
    int m_cnt = 0;

    logic [31:0] exp_data_q[$];
    logic [15:0] exp_len_q[$];
    logic        exp_trunc_q[$];

    always #5 clk = ~clk;

    axis2fifo #(.DATA_W(32), .AXIS_LEN_W(16)) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en),
        .len_o(len), .done_o(done), .overflow_o(ovf),
`ifdef AXIS2FIFO_MAX_LEN_EN
        .max_len_i(max_len), .trunc_o(trunc),
`endif
        .axis_tvalid_i(tvalid), .axis_tdata_i(tdata), .axis_tlast_i(tlast),
        .axis_tready_o(tready), .fifo_full_i(full),
        .fifo_write_o(fwrite), .fifo_wdata_o(fwdata)
    );

    axis2fifo #(.DATA_W(32), .AXIS_LEN_W(2)) dut_s (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en),
        .len_o(len_s), .done_o(done_s), .overflow_o(ovf_s),
`ifdef AXIS2FIFO_MAX_LEN_EN
        .max_len_i(max_len[1:0]), .trunc_o(trunc_s),
`endif
        .axis_tvalid_i(tvalid), .axis_tdata_i(tdata), .axis_tlast_i(tlast),
        .axis_tready_o(tready_s), .fifo_full_i(full),
        .fifo_write_o(fwrite_s), .fifo_wdata_o(fwdata_s)
    );

`ifndef AXIS2FIFO_MAX_LEN_EN
    assign trunc   = 1'b0;
    assign trunc_s = 1'b0;
`endif

    // Monitor: outputs are checked before this cycle's accept is recorded.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (fwrite) begin
                writes++;
                checks++;
                if (full) begin
                    failures++;
                    $display("FAIL write_while_full: fifo_write_o=1 with fifo_full_i=1 at cycle %0d", cyc);
                end else if (exp_data_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: wdata=%h with empty scoreboard", fwdata);
                end else begin
                    logic [31:0] e;
                    e = exp_data_q.pop_front();
                    if (fwdata !== e) begin
                        failures++;
                        $display("FAIL wdata_order: got %h expected %h", fwdata, e);
                    end
                end
            end
            if (done) begin
                dones++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                checks++;
                if (exp_len_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: len_o=%0d with no frame expected", len);
                end else begin
                    logic [15:0] el;
                    logic        et;
                    el = exp_len_q.pop_front();
                    et = exp_trunc_q.pop_front();
                    if (len !== el) begin
                        failures++;
                        $display("FAIL done_len: got %0d expected %0d", len, el);
                    end
`ifdef AXIS2FIFO_MAX_LEN_EN
                    checks++;
                    if (trunc !== et) begin
                        failures++;
                        $display("FAIL done_trunc: got %b expected %b", trunc, et);
                    end
`endif
                end
            end
            if (tvalid && tready) begin
                exp_data_q.push_back(tdata);
                m_cnt++;
                if (tlast || (max_len != 0 && m_cnt == int'(max_len))) begin
                    exp_len_q.push_back(16'(m_cnt));
                    exp_trunc_q.push_back(!tlast);
                    m_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_model();
        exp_data_q.delete();
        exp_len_q.delete();
        exp_trunc_q.delete();
        m_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int t = 0;
        tvalid = 1'b1; tdata = d; tlast = l;
        @(negedge clk);
        while (!tready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: tready stayed %b for data %h", tready, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) send_beat(base + 32'(i), i == n - 1);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        repeat (2) @(posedge clk);
        #1; tvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b expected 0", tready); end
        checks++;
        if (fwrite !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_strobes: write=%b done=%b expected 0 0", fwrite, done);
        end
        checks++;
        if (len !== 16'd0 || ovf !== 1'b0 || ovf_s !== 1'b0) begin
            failures++; $display("FAIL reset_state: len=%0d ovf=%b ovf_s=%b expected 0 0 0", len, ovf, ovf_s);
        end
        @(posedge clk); #1;
        tvalid = 1'b0; rst = 1'b0;
        clear_model();
    endtask

    task automatic test_single_frame();
        int d0 = dones;
        for (int i = 0; i < 4; i++) begin
            tvalid = 1'b1; tdata = 32'hA0 + 32'(i); tlast = (i == 3);
            @(negedge clk);
            checks++;
            if (tready !== 1'b1) begin failures++; $display("FAIL single_tready: beat %0d got %b expected 1", i, tready); end
            if (i > 0) begin
                checks++;
                if (fwrite !== 1'b1 || fwdata !== 32'hA0 + 32'(i - 1)) begin
                    failures++;
                    $display("FAIL single_latency: beat %0d write=%b data=%h expected 1 %h", i - 1, fwrite, fwdata, 32'hA0 + 32'(i - 1));
                end
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        checks++;
        if (fwrite !== 1'b1 || fwdata !== 32'hA3) begin
            failures++; $display("FAIL single_last_write: write=%b data=%h expected 1 a3", fwrite, fwdata);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || len !== 16'd4) begin
            failures++; $display("FAIL single_done: done=%b len=%0d expected 1 4", done, len);
        end
        settle();
        checks++;
        if (dones - d0 !== 1) begin failures++; $display("FAIL single_done_count: got %0d expected 1", dones - d0); end
    endtask

    task automatic test_fifo_full();
        int w0 = writes;
        int d0 = dones;
        send_beat(32'hA0, 1'b0);
        send_beat(32'hA1, 1'b0);
        full = 1'b1; tvalid = 1'b1; tdata = 32'hA2; tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tready !== 1'b0 || fwrite !== 1'b0) begin
                failures++; $display("FAIL full_stall: cycle %0d tready=%b write=%b expected 0 0", i, tready, fwrite);
            end
            @(posedge clk); #1;
        end
        full = 1'b0;
        send_beat(32'hA2, 1'b0);
        send_beat(32'hA3, 1'b1);
        tvalid = 1'b0; tlast = 1'b0;
        settle();
        checks++;
        if (writes - w0 !== 4 || dones - d0 !== 1 || len !== 16'd4) begin
            failures++;
            $display("FAIL full_totals: writes=%0d dones=%0d len=%0d expected 4 1 4", writes - w0, dones - d0, len);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = dones;
        send_beat(32'hB0, 1'b0);
        send_beat(32'hB1, 1'b0);
        send_beat(32'hB2, 1'b1);
        send_beat(32'hC0, 1'b1);
        tvalid = 1'b0; tlast = 1'b0;
        settle();
        checks++;
        if (dones - d0 !== 2 || len !== 16'd1) begin
            failures++; $display("FAIL b2b_totals: dones=%0d len=%0d expected 2 1", dones - d0, len);
        end
        checks++;
        if (last_done_cyc - prev_done_cyc !== 1) begin
            failures++; $display("FAIL b2b_gap: done spacing %0d cycles expected 1", last_done_cyc - prev_done_cyc);
        end
    endtask

    task automatic test_en_low();
        int w0 = writes;
        send_beat(32'hE0, 1'b0);
        send_beat(32'hE1, 1'b0);
        en = 1'b0; tvalid = 1'b1; tdata = 32'hE2; tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tready !== 1'b0) begin failures++; $display("FAIL en_low_tready: got %b expected 0", tready); end
            @(posedge clk); #1;
        end
        checks++;
        if (writes - w0 !== 2) begin failures++; $display("FAIL en_low_drain: writes=%0d expected 2", writes - w0); end
        en = 1'b1;
        send_beat(32'hE2, 1'b0);
        send_beat(32'hE3, 1'b1);
        tvalid = 1'b0; tlast = 1'b0;
        settle();
        checks++;
        if (len !== 16'd4) begin failures++; $display("FAIL en_low_len: got %0d expected 4", len); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_frame(3, 32'h30);
        settle();
        checks++;
        if (ovf_s !== 1'b0 || len_s !== 2'd3) begin
            failures++; $display("FAIL ovf_exact: ovf=%b len=%0d expected 0 3", ovf_s, len_s);
        end
        send_frame(5, 32'h50);
        settle();
        checks++;
        if (ovf_s !== 1'b1 || len_s !== 2'd3 || ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_sat: ovf_s=%b len_s=%0d ovf=%b expected 1 3 0", ovf_s, len_s, ovf);
        end
        send_frame(1, 32'h70);
        settle();
        checks++;
        if (ovf_s !== 1'b1 || len_s !== 2'd1) begin
            failures++; $display("FAIL ovf_sticky: ovf=%b len=%0d expected 1 1", ovf_s, len_s);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (ovf_s !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", ovf_s); end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        send_beat(32'hD0, 1'b0);
        send_beat(32'hD1, 1'b0);
        full = 1'b1; tvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tready !== 1'b0 || fwrite !== 1'b0) begin
            failures++; $display("FAIL midrst_strobes: tready=%b write=%b expected 0 0", tready, fwrite);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; full = 1'b0;
        clear_model();
        d0 = dones;
        @(negedge clk);
        checks++;
        if (fwrite !== 1'b0) begin failures++; $display("FAIL midrst_drop: write=%b expected 0", fwrite); end
        @(posedge clk); #1;
        send_frame(3, 32'hF0);
        settle();
        checks++;
        if (dones - d0 !== 1 || len !== 16'd3) begin
            failures++; $display("FAIL midrst_frame: dones=%0d len=%0d expected 1 3", dones - d0, len);
        end
    endtask

`ifdef AXIS2FIFO_MAX_LEN_EN
    task automatic test_max_len();
        int d0;
        max_len = 16'd2;
        do_reset();
        d0 = dones;
        send_frame(5, 32'h90);
        settle();
        checks++;
        if (dones - d0 !== 3 || len !== 16'd1) begin
            failures++; $display("FAIL maxlen_totals: dones=%0d len=%0d expected 3 1", dones - d0, len);
        end
        max_len = 16'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_fifo_full();
        test_back_to_back();
        test_en_low();
        test_overflow();
        test_reset_mid_frame();
`ifdef AXIS2FIFO_MAX_LEN_EN
        test_max_len();
`endif
        checks++;
        if (exp_data_q.size() != 0 || exp_len_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: data=%0d frames=%0d expected 0 0", exp_data_q.size(), exp_len_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
